// File: rtl/mem_access_stage.sv
// EX/MEM slot plus data-memory access FSM and MEM/WB result registers.
// Optional MISALIGN_TRAP_EN: misaligned h/w accesses skip the bus and retire with misalign_w set.
module mem_access_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_e,
  input  logic                     reg_write_e,
  input  logic [1:0]               res_src_e,
  input  logic                     mem_write_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  output logic                     stall_m,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  output logic [3:0]               dmem_be,
  input  logic                     dmem_ready,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic                     valid_w,
  output logic                     reg_write_w,
  output logic [1:0]               res_src_w,
  output logic [4:0]               rd_w,
  output logic [DATA_WIDTH-1:0]    alu_result_w,
  output logic [DATA_WIDTH-1:0]    read_data_w,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_w,
  output logic                     misalign_w
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t                     state_r;
  logic                       slot_valid_r;
  logic                       slot_reg_write_r;
  logic                       slot_mem_r;
  logic                       slot_misalign_r;
  logic [1:0]                 slot_res_src_r;
  logic [2:0]                 slot_funct3_r;
  logic [DATA_WIDTH-1:0]      slot_alu_r;
  logic [4:0]                 slot_rd_r;
  logic [ADDRESS_WIDTH-1:0]   slot_pc4_r;
  logic                       we_r;
  logic [3:0]                 be_r;
  logic [DATA_WIDTH-1:0]      wdata_r;
  logic                       mem_e_s;
  logic                       misalign_e_s;
  logic                       mem_go_e_s;
  logic                       retire_s;

  // Access size: 0 byte, 1 half, 2 word (undefined encodings act as word).
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = 2'd0;
      3'b001, 3'b101: size_of = 2'd1;
      default:        size_of = 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (size_of(f3))
      2'd0:    store_be = 4'b0001 << a;
      2'd1:    store_be = a[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (size_of(f3))
      2'd0:    store_wdata = {4{wd[7:0]}};
      2'd1:    store_wdata = {2{wd[15:0]}};
      default: store_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> {a, 3'b000});
    h = 16'(rdata >> {a[1], 4'b0000});
    case (size_of(f3))
      2'd0:    load_format = f3[2] ? {24'h000000, b} : {{24{b[7]}}, b};
      2'd1:    load_format = f3[2] ? {16'h0000, h} : {{16{h[15]}}, h};
      default: load_format = rdata;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
`ifdef MISALIGN_TRAP_EN
    case (size_of(f3))
      2'd1:    is_misaligned = a[0];
      2'd2:    is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
`else
    is_misaligned = 1'b0;
`endif
  endfunction

  assign mem_e_s      = valid_e & (mem_write_e | (res_src_e == 2'b01));
  assign misalign_e_s = mem_e_s & is_misaligned(funct3_e, alu_result_e[1:0]);
  assign mem_go_e_s   = mem_e_s & ~misalign_e_s;

  assign stall_m    = (state_r == ACCESS) & ~dmem_ready;
  assign dmem_req   = (state_r == ACCESS);
  assign dmem_we    = we_r;
  assign dmem_be    = be_r;
  assign dmem_wdata = wdata_r;
  assign dmem_addr  = ADDRESS_WIDTH'(slot_alu_r);

  // A slot whose access is still outstanding cannot retire; everything else retires next edge.
  assign retire_s = slot_valid_r & (~slot_mem_r | ((state_r == ACCESS) & dmem_ready));

  // EX/MEM slot capture, pre-formatted store lanes and access FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= IDLE;
      slot_valid_r     <= 1'b0;
      slot_reg_write_r <= 1'b0;
      slot_mem_r       <= 1'b0;
      slot_misalign_r  <= 1'b0;
      slot_res_src_r   <= 2'b00;
      slot_funct3_r    <= 3'b000;
      slot_alu_r       <= '0;
      slot_rd_r        <= 5'd0;
      slot_pc4_r       <= '0;
      we_r             <= 1'b0;
      be_r             <= 4'b0000;
      wdata_r          <= '0;
    end else if (!stall_m) begin
      state_r          <= mem_go_e_s ? ACCESS : IDLE;
      slot_valid_r     <= valid_e;
      slot_reg_write_r <= reg_write_e;
      slot_mem_r       <= mem_go_e_s;
      slot_misalign_r  <= misalign_e_s;
      slot_res_src_r   <= res_src_e;
      slot_funct3_r    <= funct3_e;
      slot_alu_r       <= alu_result_e;
      slot_rd_r        <= rd_e;
      slot_pc4_r       <= pc_plus4_e;
      we_r             <= mem_go_e_s & mem_write_e;
      be_r             <= mem_go_e_s ? (mem_write_e ? store_be(funct3_e, alu_result_e[1:0])
                                                    : 4'b1111) : 4'b0000;
      wdata_r          <= (mem_go_e_s & mem_write_e) ? store_wdata(funct3_e, write_data_e) : '0;
    end
  end

  // MEM/WB registers; payload holds whenever nothing retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      res_src_w    <= 2'b00;
      rd_w         <= 5'd0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
      misalign_w   <= 1'b0;
    end else begin
      valid_w <= retire_s;
      if (retire_s) begin
        reg_write_w  <= slot_reg_write_r & ~slot_misalign_r;
        res_src_w    <= slot_res_src_r;
        rd_w         <= slot_rd_r;
        alu_result_w <= slot_alu_r;
        pc_plus4_w   <= slot_pc4_r;
        misalign_w   <= slot_misalign_r;
        if (slot_mem_r) begin
          read_data_w <= load_format(slot_funct3_r, slot_alu_r[1:0], dmem_rdata);
        end
      end
    end
  end

endmodule
